vlan_tagger: RTL and testbench

- Upstream neighbour of the VLAN removal stage, on the 256-bit AXI4-Stream datapath.
- Inserts an 802.1Q tag after the source MAC address of untagged frames whose source port matches a configured mask.
- Increments the packet-length field in tuser by 4.
- Re-aligns the rest of the frame by 4 bytes, adding a trailing beat when required.
- Tagged frames and frames from non-matching ports pass unchanged.

---
 rtl/vlan_tagger.sv | 193 +++++++++++++++++++
 tb/tb_vlan_tagger.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlan_tagger.sv
// rtl/vlan_tagger.sv - inserts an 802.1Q tag into untagged frames from selected source ports
module vlan_tagger #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          SRC_PORT_POS         = 16,
  parameter logic [7:0]  TAG_PORT_MASK        = 8'h05,
  parameter int          FIFO_DEPTH_BITS      = 2
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [11:0]                       cfg_vid,
  input  logic [2:0]                        cfg_pcp,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       tagged_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  typedef enum logic [1:0] {HEADER, PASS, TAG_BODY, EXTRA} state_t;

  logic [255:0] mem_data [DEPTH];
  logic [31:0]  mem_keep [DEPTH];
  logic [127:0] mem_user [DEPTH];
  logic         mem_last [DEPTH];

  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       fifo_wr, fifo_rd, fifo_empty;

  logic [255:0] head_data;
  logic [31:0]  head_keep;
  logic [127:0] head_user;
  logic         head_last;

  state_t       state;
  logic [31:0]  carry;
  logic [3:0]   carry_keep;
  logic         is_tag, xfer;
  logic [15:0]  tci;
  logic [31:0]  tag_field;

  assign fifo_empty    = (count == '0);
  // Headroom of one entry keeps ready independent of the same-cycle read.
  assign s_axis_tready = (count < (FIFO_DEPTH_BITS+1)'(DEPTH - 1));
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;

  assign head_data = mem_data[rd_ptr];
  assign head_keep = mem_keep[rd_ptr];
  assign head_user = mem_user[rd_ptr];
  assign head_last = mem_last[rd_ptr];

  always_ff @(posedge axis_aclk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr] <= s_axis_tdata;
      mem_keep[wr_ptr] <= s_axis_tkeep;
      mem_user[wr_ptr] <= s_axis_tuser;
      mem_last[wr_ptr] <= s_axis_tlast;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign tci       = {cfg_pcp, 1'b0, cfg_vid};
  assign tag_field = {tci[7:0], tci[15:8], 16'h0081};
  assign is_tag    = ((head_user[SRC_PORT_POS +: 8] & TAG_PORT_MASK) != 8'd0) &&
                     (head_data[111:96] != 16'h0081) && head_keep[11];

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      HEADER: begin
        if (!fifo_empty) begin
          m_axis_tvalid = 1'b1;
          if (is_tag) begin
            m_axis_tdata = {head_data[223:96], tag_field, head_data[95:0]};
            m_axis_tkeep = {head_keep[27:0], 4'hF};
            m_axis_tuser = {head_user[127:16], head_user[15:0] + 16'd4};
            m_axis_tlast = head_last && (head_keep[31:28] == 4'd0);
          end else begin
            m_axis_tdata = head_data;
            m_axis_tkeep = head_keep;
            m_axis_tuser = head_user;
            m_axis_tlast = head_last;
          end
        end
      end
      PASS: begin
        if (!fifo_empty) begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = head_data;
          m_axis_tkeep  = head_keep;
          m_axis_tuser  = head_user;
          m_axis_tlast  = head_last;
        end
      end
      TAG_BODY: begin
        if (!fifo_empty) begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = {head_data[223:0], carry};
          m_axis_tkeep  = {head_keep[27:0], carry_keep};
          m_axis_tlast  = head_last && (head_keep[31:28] == 4'd0);
        end
      end
      default: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {224'd0, carry};
        m_axis_tkeep  = {28'd0, carry_keep};
        m_axis_tlast  = 1'b1;
      end
    endcase
  end

  assign xfer    = m_axis_tvalid && m_axis_tready;
  assign fifo_rd = xfer && (state != EXTRA);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state        <= HEADER;
      carry        <= '0;
      carry_keep   <= '0;
      tagged_count <= '0;
    end else if (xfer) begin
      case (state)
        HEADER: begin
          if (is_tag) begin
            carry      <= head_data[255:224];
            carry_keep <= head_keep[31:28];
            if (!head_last) begin
              state <= TAG_BODY;
            end else if (head_keep[31:28] == 4'd0) begin
              tagged_count <= tagged_count + 32'd1;
            end else begin
              state <= EXTRA;
            end
          end else if (!head_last) begin
            state <= PASS;
          end
        end
        PASS: begin
          if (head_last) state <= HEADER;
        end
        TAG_BODY: begin
          carry      <= head_data[255:224];
          carry_keep <= head_keep[31:28];
          if (head_last) begin
            if (head_keep[31:28] == 4'd0) begin
              state        <= HEADER;
              tagged_count <= tagged_count + 32'd1;
            end else begin
              state <= EXTRA;
            end
          end
        end
        default: begin
          state        <= HEADER;
          tagged_count <= tagged_count + 32'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vlan_tagger.sv
// tb/tb_vlan_tagger.sv - scoreboard bench for vlan_tagger
module tb_vlan_tagger;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  src;
    logic        pretag;
    logic [11:0] vid;
    logic [2:0]  pcp;
    logic        gaps;
    int          exp_bytes;
    int          exp_inc;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [11:0]  cfg_vid;
  logic [2:0]   cfg_pcp;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tvalid, s_tready, s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  tagged_count;

  int assertions = 0;
  int failures   = 0;
  int out_bytes  = 0;
  int ready_mode = 0;

  beat_t        exp_q[$];
  logic [7:0]   fb[$];
  logic [127:0] tuser_val;
  vec_t         vecs[9];

  vlan_tagger dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .cfg_vid       (cfg_vid),
    .cfg_pcp       (cfg_pcp),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .tagged_count  (tagged_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Pops one expected beat per transfer; also checks stall stability.
  logic         prev_stall = 1'b0;
  beat_t        held;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {255'd0, m_tvalid}, 256'd1);
        check("stall_data", m_tdata, held.data);
        check("stall_side", {m_tuser, m_tkeep, m_tlast}, {held.user, held.keep, held.last});
      end
      if (m_tvalid && m_tready) begin
        out_bytes += $countones(m_tkeep);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {255'd0, m_tvalid}, 256'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_tdata, e.data);
          check("beat_keep", {224'd0, m_tkeep}, {224'd0, e.keep});
          check("beat_user", {128'd0, m_tuser}, {128'd0, e.user});
          check("beat_last", {255'd0, m_tlast}, {255'd0, e.last});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      held.data  = m_tdata;
      held.keep  = m_tkeep;
      held.user  = m_tuser;
      held.last  = m_tlast;
    end
  end

  task automatic build_frame(input int len, input logic [7:0] src, input logic pretag);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    if (pretag && len >= 14) begin
      fb[12] = 8'h81;
      fb[13] = 8'h00;
    end else if (len >= 14 && fb[12] == 8'h81 && fb[13] == 8'h00) begin
      fb[13] = 8'h01;
    end
    tuser_val = {$urandom, $urandom, $urandom, $urandom};
    tuser_val[23:16] = src;
    tuser_val[15:0]  = 16'(len);
  endtask

  // Byte-level reference: splice the tag bytes in, then re-chunk into 32-byte beats.
  task automatic push_expected(input logic [11:0] vid, input logic [2:0] pcp);
    logic [7:0] ob[$];
    logic       tag;
    int         nb;
    beat_t      b;
    tag = ((tuser_val[23:16] & 8'h05) != 0) && (fb.size() >= 12) &&
          !(fb.size() >= 14 && fb[12] == 8'h81 && fb[13] == 8'h00);
    ob = fb;
    if (tag) begin
      ob.insert(12, 8'h81);
      ob.insert(13, 8'h00);
      ob.insert(14, {pcp, 1'b0, vid[11:8]});
      ob.insert(15, vid[7:0]);
    end
    nb = (ob.size() + 31) / 32;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int i = 0; i < 32; i++) begin
        if (k * 32 + i < ob.size()) begin
          b.data[8*i +: 8] = ob[k*32 + i];
          b.keep[i] = 1'b1;
        end
      end
      if (!tag)       b.user = tuser_val;
      else if (k == 0) b.user = {tuser_val[127:16], 16'(fb.size() + 4)};
      else            b.user = '0;
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_frame(input logic gaps, input int max_beats);
    int nb, w;
    nb = (fb.size() + 31) / 32;
    for (int k = 0; k < nb && k < max_beats; k++) begin
      s_tdata = '0;
      s_tkeep = '0;
      for (int i = 0; i < 32; i++) begin
        if (k * 32 + i < fb.size()) begin
          s_tdata[8*i +: 8] = fb[k*32 + i];
          s_tkeep[i] = 1'b1;
        end
      end
      s_tuser  = tuser_val;
      s_tlast  = (k == nb - 1);
      s_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!s_tready) check("input_ready_timeout", {255'd0, s_tready}, 256'd1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    s_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 256'(exp_q.size()), 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int len, input logic [7:0] src, input logic pretag,
                           input logic gaps, input int exp_bytes, input int exp_inc,
                           input string tag_name);
    logic [31:0] cnt0;
    build_frame(len, src, pretag);
    push_expected(cfg_vid, cfg_pcp);
    cnt0      = tagged_count;
    out_bytes = 0;
    drive_frame(gaps, 1 << 20);
    wait_drain();
    check({tag_name, "_bytes"}, 256'(out_bytes), 256'(exp_bytes));
    check({tag_name, "_count"}, 256'(tagged_count - cnt0), 256'(exp_inc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{60, 8'h01, 1'b0, 12'h064, 3'd0, 1'b0, 64, 1};
    vecs[1] = '{60, 8'h01, 1'b1, 12'h064, 3'd0, 1'b0, 60, 0};
    vecs[2] = '{60, 8'h02, 1'b0, 12'h064, 3'd0, 1'b0, 60, 0};
    vecs[3] = '{30, 8'h04, 1'b0, 12'h123, 3'd5, 1'b0, 34, 1};
    vecs[4] = '{64, 8'h05, 1'b0, 12'hFFF, 3'd7, 1'b1, 68, 1};
    vecs[5] = '{32, 8'h01, 1'b0, 12'h001, 3'd1, 1'b0, 36, 1};
    vecs[6] = '{28, 8'h04, 1'b0, 12'h0AB, 3'd2, 1'b0, 32, 1};
    vecs[7] = '{11, 8'h01, 1'b0, 12'h064, 3'd0, 1'b0, 11, 0};
    vecs[8] = '{96, 8'h80, 1'b0, 12'h064, 3'd0, 1'b1, 96, 0};

    rst_n    = 1'b0;
    cfg_vid  = 12'h064;
    cfg_pcp  = 3'd0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", {255'd0, m_tvalid}, 256'd0);
    check("rst_m_tdata", m_tdata, 256'd0);
    check("rst_tagged_count", {224'd0, tagged_count}, 256'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_s_tready", {255'd0, s_tready}, 256'd1);

    for (int i = 0; i < 9; i++) begin
      cfg_vid    = vecs[i].vid;
      cfg_pcp    = vecs[i].pcp;
      ready_mode = i % 2;
      run_frame(vecs[i].len, vecs[i].src, vecs[i].pretag, vecs[i].gaps,
                vecs[i].exp_bytes, vecs[i].exp_inc, $sformatf("vec%0d", i));
    end

    cfg_vid    = 12'h5A5;
    cfg_pcp    = 3'd3;
    ready_mode = 1;
    run_frame(1518, 8'h01, 1'b0, 1'b1, 1522, 1, "jumbo");

    // Abandon a stalled tagged frame with an asynchronous reset.
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    build_frame(200, 8'h01, 1'b0);
    drive_frame(1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", {255'd0, m_tvalid}, 256'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {255'd0, m_tvalid}, 256'd0);
    check("async_rst_count", {224'd0, tagged_count}, 256'd0);
    check("async_rst_data", m_tdata, 256'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n      = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    cfg_vid = 12'h0C8;
    cfg_pcp = 3'd6;
    run_frame(64, 8'h01, 1'b0, 1'b0, 68, 1, "post_rst");
    check("post_rst_total", {224'd0, tagged_count}, 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
